minv_mdiv: RTL and testbench

- 256-bit modular inversion / modular division engine over an odd modulus p, using the binary extended Euclidean algorithm.
- Operands a, b and p are loaded over a 16-bit word bus.
- The engine computes a^-1 mod p when minv_mdiv=1, or b·a^-1 mod p when minv_mdiv=0.
- The result is streamed out in 16-bit words. The block is a coprocessor for ECC (SM2-class) point arithmetic.

---
 rtl/minv_mdiv_pkg.sv | 16 +
 rtl/minv_mdiv_if.sv | 28 ++
 rtl/mod_half_sub.sv | 26 ++
 rtl/minv_mdiv.sv | 193 +++++++++++++++++++
 tb/tb_minv_mdiv.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minv_mdiv_pkg.sv
// Shared constants and FSM state encoding for the modular inversion/division engine.
package minv_mdiv_pkg;

  localparam int unsigned WIDTH  = 256;
  localparam int unsigned WORD   = 16;
  localparam int unsigned NWORDS = WIDTH / WORD;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOOP,
    FINAL,
    DONE
  } state_t;

endpackage

// File: rtl/minv_mdiv_if.sv
// Word bus, strobes and status of the engine, bundled for host and engine sides.
interface minv_mdiv_if;
  import minv_mdiv_pkg::*;

  logic [WORD-1:0] datain;
  logic            minv_mdiv;
  logic            minv_mdiv_en;
  logic            loada;
  logic            loadb;
  logic            loadp;
  logic            outx1;
  logic            outx2;
  logic [WORD-1:0] regx1out;
  logic [WORD-1:0] regx2out;
  logic            minv_mdiv_rdy;
  logic            minv_mdiv_flag;

  modport master (
    output datain, minv_mdiv, minv_mdiv_en, loada, loadb, loadp, outx1, outx2,
    input  regx1out, regx2out, minv_mdiv_rdy, minv_mdiv_flag
  );

  modport slave (
    input  datain, minv_mdiv, minv_mdiv_en, loada, loadb, loadp, outx1, outx2,
    output regx1out, regx2out, minv_mdiv_rdy, minv_mdiv_flag
  );

endinterface

// File: rtl/mod_half_sub.sv
// Combinational modular helpers for one coefficient path:
//   half = x/2 mod p, diff = (x - y) mod p, with x, y < p and p odd.
module mod_half_sub
  import minv_mdiv_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] half,
  output logic [WIDTH-1:0] diff
);

  // For odd x and odd p, (x+p)>>1 == (x>>1) + (p>>1) + 1, which never needs
  // the 257th bit; the subtraction wraps mod 2^WIDTH and p restores range on borrow.
  always_comb begin
    half = x >> 1;
    if (x[0]) begin
      half = (x >> 1) + (p >> 1) + WIDTH'(1);
    end
    diff = x - y;
    if (x < y) begin
      diff = x - y + p;
    end
  end

endmodule

// File: rtl/minv_mdiv.sv
// 256-bit modular inversion (a^-1 mod p) / division (b*a^-1 mod p) engine using
// the binary extended Euclidean algorithm, with a 16-bit word load/unload bus.
module minv_mdiv
  import minv_mdiv_pkg::*;
(
  input logic         clk,
  input logic         rst,
  minv_mdiv_if.slave  bus
);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             mode;
  logic             flag;
  logic             rdy;

  logic             host_phase;
  logic             u_one;
  logic             v_one;
  logic             u_zero;
  logic             v_zero;
  logic             u_ge_v;
  logic [WIDTH-1:0] x1_half;
  logic [WIDTH-1:0] x1_diff;
  logic [WIDTH-1:0] x2_half;
  logic [WIDTH-1:0] x2_diff;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] r_neg;

  // x1 path: x1/2 and x1-x2 (mod p)
  mod_half_sub u_x1_path (
    .x    (x1),
    .y    (x2),
    .p    (p_r),
    .half (x1_half),
    .diff (x1_diff)
  );

  // x2 path: x2/2 and x2-x1 (mod p)
  mod_half_sub u_x2_path (
    .x    (x2),
    .y    (x1),
    .p    (p_r),
    .half (x2_half),
    .diff (x2_diff)
  );

  // Loop tests and final result selection
  always_comb begin
    host_phase = (state == IDLE) || (state == DONE);
    u_one      = (u == WIDTH'(1));
    v_one      = (v == WIDTH'(1));
    u_zero     = (u == '0);
    v_zero     = (v == '0);
    u_ge_v     = (u >= v);
    r_sel      = u_one ? x1 : x2;
    r_neg      = '0;
    if (r_sel != '0) begin
      r_neg = p_r - r_sel;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (bus.minv_mdiv_en) begin
          state_next = INIT;
        end
      end
      INIT:  state_next = LOOP;
      LOOP: begin
        if (u_one || v_one || u_zero || v_zero) begin
          state_next = FINAL;
        end
      end
      FINAL:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand load shift registers, only writable while the engine is not busy
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else if (host_phase) begin
      if (bus.loada) begin
        a_r <= {bus.datain, a_r[WIDTH-1:WORD]};
      end
      if (bus.loadb) begin
        b_r <= {bus.datain, b_r[WIDTH-1:WORD]};
      end
      if (bus.loadp) begin
        p_r <= {bus.datain, p_r[WIDTH-1:WORD]};
      end
    end
  end

  // Euclid datapath, status flags and result/output rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      u    <= '0;
      v    <= '0;
      x1   <= '0;
      x2   <= '0;
      mode <= 1'b0;
      flag <= 1'b0;
      rdy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.minv_mdiv_en) begin
            mode <= bus.minv_mdiv;
          end
          // x1/x2 double as the result registers, so rotation happens in place.
          if (state == DONE) begin
            if (bus.outx1) begin
              x1 <= {x1[WORD-1:0], x1[WIDTH-1:WORD]};
            end
            if (bus.outx2) begin
              x2 <= {x2[WORD-1:0], x2[WIDTH-1:WORD]};
            end
          end
        end
        INIT: begin
          u    <= a_r;
          v    <= p_r;
          x1   <= mode ? WIDTH'(1) : b_r;
          x2   <= '0;
          flag <= 1'b0;
          rdy  <= 1'b0;
        end
        LOOP: begin
          if (u_one || v_one) begin
            // converged; FINAL picks the coefficient
          end else if (u_zero || v_zero) begin
            flag <= 1'b1;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u_ge_v) begin
            u  <= u - v;
            x1 <= x1_diff;
          end else begin
            v  <= v - u;
            x2 <= x2_diff;
          end
        end
        FINAL: begin
          if (flag) begin
            x1 <= '0;
            x2 <= '0;
          end else begin
            x1 <= r_sel;
            x2 <= r_neg;
          end
          rdy <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.regx1out       = x1[WORD-1:0];
  assign bus.regx2out       = x2[WORD-1:0];
  assign bus.minv_mdiv_rdy  = rdy;
  assign bus.minv_mdiv_flag = flag;

endmodule

// File: tb/tb_minv_mdiv.sv
// Self-checking bench for minv_mdiv: vector table plus scoreboard, with
// hand-written sequences for abort, ignored strobes and output rotation.
module tb_minv_mdiv;
  import minv_mdiv_pkg::*;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic         mode;
    logic         flag;
    logic [255:0] x1;
    logic [255:0] x2;
  } vec_t;

  typedef struct {
    logic         flag;
    logic [255:0] x1;
    logic [255:0] x2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minv_mdiv_if bus ();

  minv_mdiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[11];

  logic [255:0] sm2_a;
  logic [255:0] sm2_b;
  logic [255:0] sm2_p;
  logic [255:0] inv_ref;
  logic [255:0] got1;
  logic [255:0] got2;
  exp_t         last_exp;

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y,
                                          input logic [255:0] m);
    logic [256:0] acc;
    acc = '0;
    for (int i = 255; i >= 0; i--) begin
      acc = {acc[255:0], 1'b0};
      if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
      if (y[i]) begin
        acc = acc + {1'b0, x};
        if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
      end
    end
    return acc[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, base, m);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load_op(input logic [255:0] val, input int unsigned sel);
    for (int w = 0; w < 16; w++) begin
      bus.datain = val[16*w +: 16];
      bus.loada  = (sel == 0);
      bus.loadb  = (sel == 1);
      bus.loadp  = (sel == 2);
      tick();
    end
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadp = 1'b0;
  endtask

  task automatic start(input logic mode, input exp_t e);
    bus.minv_mdiv    = mode;
    bus.minv_mdiv_en = 1'b1;
    tick();
    bus.minv_mdiv_en = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.minv_mdiv_rdy !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    n = 0;
    while (bus.minv_mdiv_rdy !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    if (bus.minv_mdiv_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for rdy", name);
    end
  endtask

  // Pops the expected result, reads both result registers word by word.
  task automatic collect(input string name, output logic [255:0] r1, output logic [255:0] r2);
    exp_t e;
    r1 = '0;
    r2 = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check({name, "_flag"}, 256'(bus.minv_mdiv_flag), 256'(e.flag));
    for (int w = 0; w < 16; w++) begin
      r1[16*w +: 16] = bus.regx1out;
      bus.outx1 = 1'b1;
      tick();
    end
    bus.outx1 = 1'b0;
    for (int w = 0; w < 16; w++) begin
      r2[16*w +: 16] = bus.regx2out;
      bus.outx2 = 1'b1;
      tick();
    end
    bus.outx2 = 1'b0;
    check({name, "_x1"}, r1, e.x1);
    check({name, "_x2"}, r2, e.x2);
    check({name, "_x1_realign"}, 256'(bus.regx1out), 256'(e.x1[15:0]));
  endtask

  task automatic run_vec(input vec_t t, input string name);
    exp_t e;
    logic [255:0] r1;
    logic [255:0] r2;
    e.flag = t.flag;
    e.x1   = t.x1;
    e.x2   = t.x2;
    load_op(t.p, 2);
    load_op(t.a, 0);
    load_op(t.b, 1);
    start(t.mode, e);
    wait_done(name);
    collect(name, r1, r2);
    got1 = r1;
    got2 = r2;
  endtask

  initial begin
    exp_t e;
    logic [255:0] r1;
    logic [255:0] r2;
    logic [255:0] pass1;
    logic [255:0] pass2;
    int           rdy_drops;

    rst              = 1'b1;
    bus.datain       = '0;
    bus.minv_mdiv    = 1'b0;
    bus.minv_mdiv_en = 1'b0;
    bus.loada        = 1'b0;
    bus.loadb        = 1'b0;
    bus.loadp        = 1'b0;
    bus.outx1        = 1'b0;
    bus.outx2        = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_rdy",  256'(bus.minv_mdiv_rdy),  256'd0);
    check("reset_flag", 256'(bus.minv_mdiv_flag), 256'd0);
    check("reset_x1",   256'(bus.regx1out),       256'd0);
    check("reset_x2",   256'(bus.regx2out),       256'd0);

    sm2_a = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
    sm2_b = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
    sm2_p = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
    inv_ref = powmod(sm2_a, sm2_p - 256'd2, sm2_p);

    vecs[0]  = '{a: 256'd5,  b: 256'd0, p: 256'd11, mode: 1'b1, flag: 1'b0, x1: 256'd9,  x2: 256'd2};
    vecs[1]  = '{a: 256'd5,  b: 256'd3, p: 256'd11, mode: 1'b0, flag: 1'b0, x1: 256'd5,  x2: 256'd6};
    vecs[2]  = '{a: 256'd6,  b: 256'd0, p: 256'd9,  mode: 1'b1, flag: 1'b1, x1: 256'd0,  x2: 256'd0};
    vecs[3]  = '{a: 256'd0,  b: 256'd0, p: 256'd11, mode: 1'b1, flag: 1'b1, x1: 256'd0,  x2: 256'd0};
    vecs[4]  = '{a: 256'd0,  b: 256'd3, p: 256'd11, mode: 1'b0, flag: 1'b1, x1: 256'd0,  x2: 256'd0};
    vecs[5]  = '{a: 256'd1,  b: 256'd0, p: 256'd11, mode: 1'b1, flag: 1'b0, x1: 256'd1,  x2: 256'd10};
    vecs[6]  = '{a: 256'd10, b: 256'd0, p: 256'd11, mode: 1'b1, flag: 1'b0, x1: 256'd10, x2: 256'd1};
    vecs[7]  = '{a: 256'd7,  b: 256'd0, p: 256'd13, mode: 1'b0, flag: 1'b0, x1: 256'd0,  x2: 256'd0};
    vecs[8]  = '{a: 256'd10, b: 256'd4, p: 256'd15, mode: 1'b0, flag: 1'b1, x1: 256'd0,  x2: 256'd0};
    vecs[9]  = '{a: sm2_a, b: sm2_b, p: sm2_p, mode: 1'b1, flag: 1'b0,
                 x1: inv_ref, x2: sm2_p - inv_ref};
    vecs[10] = '{a: sm2_a, b: sm2_b, p: sm2_p, mode: 1'b0, flag: 1'b0,
                 x1: mulmod(sm2_b, inv_ref, sm2_p), x2: sm2_p - mulmod(sm2_b, inv_ref, sm2_p)};

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Independent product check on the last two 256-bit results.
    run_vec(vecs[9], "sm2_inv_prod");
    check("sm2_inv_times_a", mulmod(got1, sm2_a, sm2_p), 256'd1);
    run_vec(vecs[10], "sm2_div_prod");
    check("sm2_div_times_a", mulmod(got1, sm2_a, sm2_p), sm2_b);

    // Rotation: 32 outx1 pulses in DONE repeat the word sequence twice.
    pass1 = '0;
    pass2 = '0;
    rdy_drops = 0;
    for (int w = 0; w < 32; w++) begin
      if (w < 16) pass1[16*w +: 16] = bus.regx1out;
      else        pass2[16*(w-16) +: 16] = bus.regx1out;
      bus.outx1 = 1'b1;
      tick();
      if (bus.minv_mdiv_rdy !== 1'b1) rdy_drops++;
    end
    bus.outx1 = 1'b0;
    check("rot_pass1", pass1, last_exp.x1);
    check("rot_pass2", pass2, last_exp.x1);
    check("rot_rdy_drops", 256'(rdy_drops), 256'd0);

    // Start, load, output strobes during LOOP must all be ignored.
    load_op(sm2_a, 0);
    e.flag = 1'b0;
    e.x1   = inv_ref;
    e.x2   = sm2_p - inv_ref;
    start(1'b1, e);
    tick();
    bus.datain       = 16'hFFFF;
    bus.minv_mdiv    = 1'b0;
    bus.minv_mdiv_en = 1'b1;
    bus.loada        = 1'b1;
    bus.loadb        = 1'b1;
    bus.loadp        = 1'b1;
    bus.outx1        = 1'b1;
    bus.outx2        = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.minv_mdiv_en = 1'b0;
    bus.loada        = 1'b0;
    bus.loadb        = 1'b0;
    bus.loadp        = 1'b0;
    bus.outx1        = 1'b0;
    bus.outx2        = 1'b0;
    wait_done("busy_ignore");
    collect("busy_ignore", r1, r2);
    // Operands survived: a restart without reloading repeats the result.
    start(1'b1, e);
    wait_done("busy_reuse");
    collect("busy_reuse", r1, r2);

    // Simultaneous strobes: a and b loaded together, b/a = 1.
    for (int w = 0; w < 16; w++) begin
      bus.datain = (w == 0) ? 16'd5 : 16'd0;
      bus.loada  = 1'b1;
      bus.loadb  = 1'b1;
      tick();
    end
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    load_op(256'd11, 2);
    e.flag = 1'b0;
    e.x1   = 256'd1;
    e.x2   = 256'd10;
    start(1'b0, e);
    wait_done("dual_load");
    collect("dual_load", r1, r2);

    // Reset mid-LOOP aborts; a fresh load then completes.
    load_op(sm2_p, 2);
    load_op(sm2_a, 0);
    e.x1 = inv_ref;
    e.x2 = sm2_p - inv_ref;
    start(1'b1, e);
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("abort_rdy",  256'(bus.minv_mdiv_rdy),  256'd0);
    check("abort_flag", 256'(bus.minv_mdiv_flag), 256'd0);
    check("abort_x1",   256'(bus.regx1out),       256'd0);
    check("abort_x2",   256'(bus.regx2out),       256'd0);
    run_vec(vecs[0], "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
